regfile_bank: RTL and testbench
===============================

REGFILE_BANK -- requirements
Module: regfile_bank

Interface
REQ-001 Parameter DATA_W, default 32, SHALL set the register data width in bits.
REQ-002 Parameter ADDR_W, default 5, SHALL set the address width; depth DEPTH = 2**ADDR_W entries.
REQ-003 Parameter NREAD, default 2, SHALL set the number of independent read ports (1..4).
REQ-004 Parameter ZERO_REG, default 1, SHALL make entry 0 read as 0 and ignore writes to it when 1.
REQ-005 clk  input  1  SHALL be the sole clock; all state changes on its rising edge.
REQ-006 reset  input  1  SHALL be a synchronous, active-high reset, sampled on rising clk.
REQ-007 rd_addr  input  NREAD*ADDR_W  SHALL carry read addresses; port k uses bits [k*ADDR_W +: ADDR_W].
REQ-008 rd_data  output  NREAD*DATA_W  SHALL carry registered read data; port k uses bits [k*DATA_W +: DATA_W].
REQ-009 wr_addr  input  ADDR_W  SHALL be the write address.
REQ-010 wr_data  input  DATA_W  SHALL be the write data.
REQ-011 wr_ena  input  1  SHALL request a write of wr_data to wr_addr this cycle.
REQ-012 clr_req  input  1  SHALL request a full clear of all entries (single-cycle pulse sufficient).
REQ-013 busy  output  1  SHALL be high while the clear sequencer runs.
REQ-014 dbg_addr  input  ADDR_W  SHALL select an entry for the debug port.
REQ-015 dbg_data  output  DATA_W  SHALL be a registered copy of the entry at dbg_addr (no bypass).

Function
REQ-016 Storage SHALL be DEPTH x DATA_W; contents SHALL NOT be cleared in one cycle (sequencer only, REQ-020).
REQ-017 Read latency SHALL be 1 cycle: rd_data[k] at edge N+1 reflects rd_addr[k] sampled at edge N.
REQ-018 Read priority per port: busy -> 0; else ZERO_REG and addr==0 -> 0; else wr_ena and wr_addr==addr (write accepted per REQ-019) -> wr_data (write-through bypass); else stored entry.
REQ-019 A write SHALL be accepted only when wr_ena=1, busy=0, reset=0, and not (ZERO_REG=1 and wr_addr==0); rejected writes SHALL leave storage unchanged.
REQ-020 Sequencer FSM states: IDLE, CLEAR; counter clr_cnt of ADDR_W bits.
REQ-021 IDLE -> CLEAR when clr_req=1; clr_cnt SHALL load 0.
REQ-022 In CLEAR each cycle SHALL write 0 to entry clr_cnt and increment clr_cnt; at clr_cnt==DEPTH-1 SHALL write that entry and return to IDLE (clear takes exactly DEPTH cycles).
REQ-023 busy SHALL be 1 exactly while state==CLEAR.
REQ-024 clr_req while in CLEAR SHALL be ignored (no restart, no extension).
REQ-025 wr_ena while busy=1 SHALL be dropped, not queued.
REQ-026 All NREAD ports SHALL operate independently; identical addresses on several ports SHALL return identical data.
REQ-027 dbg_data SHALL return 0 for entry 0 when ZERO_REG=1 and SHALL otherwise show stored contents even while busy.

Reset
REQ-028 On reset=1 at a rising edge: state SHALL go to CLEAR, clr_cnt to 0, busy to 1 on the next cycle, rd_data and dbg_data to 0.
REQ-029 Reset asserted mid-CLEAR SHALL restart the sequence from entry 0.
REQ-030 After reset deassertion the block SHALL be usable (busy=0) after DEPTH cycles, with all entries 0.
REQ-031 A write coinciding with reset SHALL be ignored.

Verification
REQ-032 Reset 1 cycle, wait DEPTH=32 cycles -> busy falls on cycle 32; all 32 entries read 0 on both ports.
REQ-033 Write 0xDEADBEEF to 5, next cycle read port0=5, port1=5 -> both return 0xDEADBEEF one cycle later.
REQ-034 Same cycle: wr_ena=1, wr_addr=7, wr_data=0x12345678, rd_addr0=7 -> rd_data0=0x12345678 next cycle (bypass).
REQ-035 Write 0xFFFFFFFF to 0 (ZERO_REG=1), then read 0 and dbg_addr=0 -> both return 0; same with wr_addr=0 and read 0 simultaneously -> 0.
REQ-036 Fill entries 1..31 with index value, pulse clr_req, issue wr_ena to 3 and clr_req again at cycle 10 -> busy exactly 32 cycles, rd_data 0 while busy, all entries 0 afterwards.
REQ-037 Reset asserted at CLEAR cycle 15 -> busy held, full 32-cycle clear restarted from entry 0; parameter sweep NREAD=1/4, DATA_W=8/64, ADDR_W=3 repeats REQ-032/033.

Source files
------------

// File: rtl/regfile_bank.sv
// Multi-port register file with a write-through bypass, a debug read port and
// a cycle-by-cycle clear sequencer (also kicked off by reset).
module regfile_bank #(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned ADDR_W   = 5,
  parameter int unsigned NREAD    = 2,
  parameter bit          ZERO_REG = 1'b1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NREAD*ADDR_W-1:0] rd_addr,
  output logic [NREAD*DATA_W-1:0] rd_data,
  input  logic [ADDR_W-1:0]       wr_addr,
  input  logic [DATA_W-1:0]       wr_data,
  input  logic                    wr_ena,
  input  logic                    clr_req,
  output logic                    busy,
  input  logic [ADDR_W-1:0]       dbg_addr,
  output logic [DATA_W-1:0]       dbg_data
);

  localparam int unsigned DEPTH = 1 << ADDR_W;

  typedef enum logic {IDLE, CLEAR} state_t;

  state_t                    state, state_next;
  logic [ADDR_W-1:0]         clr_cnt, clr_cnt_next;
  logic [DATA_W-1:0]         mem [DEPTH];
  logic                      clearing;
  logic                      wr_acc;
  logic [NREAD*DATA_W-1:0]   rd_next;
  logic [DATA_W-1:0]         dbg_next;

  assign clearing = (state == CLEAR);
  assign wr_acc   = wr_ena && !clearing && !reset && !(ZERO_REG && (wr_addr == '0));

  // Sequencer state register; reset (re)starts a full clear from entry 0.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= CLEAR;
      clr_cnt <= '0;
      busy    <= 1'b1;
    end else begin
      state   <= state_next;
      clr_cnt <= clr_cnt_next;
      busy    <= (state_next == CLEAR);
    end
  end

  // Next-state logic: a clear request is only honoured from IDLE.
  always_comb begin
    state_next   = state;
    clr_cnt_next = clr_cnt;
    unique case (state)
      IDLE: begin
        if (clr_req) begin
          state_next   = CLEAR;
          clr_cnt_next = '0;
        end
      end
      CLEAR: begin
        clr_cnt_next = clr_cnt + ADDR_W'(1);
        if (clr_cnt == ADDR_W'(DEPTH - 1)) begin
          state_next = IDLE;
        end
      end
    endcase
  end

  // Storage: the sequencer owns the array while clearing, user writes otherwise.
  always_ff @(posedge clk) begin
    if (clearing) begin
      mem[clr_cnt] <= '0;
    end else if (wr_acc) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // Per-port read select with write-through bypass of an accepted write.
  always_comb begin
    rd_next = '0;
    for (int k = 0; k < NREAD; k++) begin
      if (clearing) begin
        rd_next[k*DATA_W +: DATA_W] = '0;
      end else if (ZERO_REG && (rd_addr[k*ADDR_W +: ADDR_W] == '0)) begin
        rd_next[k*DATA_W +: DATA_W] = '0;
      end else if (wr_acc && (wr_addr == rd_addr[k*ADDR_W +: ADDR_W])) begin
        rd_next[k*DATA_W +: DATA_W] = wr_data;
      end else begin
        rd_next[k*DATA_W +: DATA_W] = mem[rd_addr[k*ADDR_W +: ADDR_W]];
      end
    end
  end

  assign dbg_next = (ZERO_REG && (dbg_addr == '0)) ? '0 : mem[dbg_addr];

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_data  <= '0;
      dbg_data <= '0;
    end else begin
      rd_data  <= rd_next;
      dbg_data <= dbg_next;
    end
  end

endmodule

// File: tb/tb_regfile_bank.sv
// Randomised bench for regfile_bank: array-based reference model checked every
// cycle, plus directed scenarios with literal expectations.
module tb_regfile_bank;

  localparam int unsigned DW    = 32;
  localparam int unsigned AW    = 5;
  localparam int unsigned NR    = 2;
  localparam int unsigned DEPTH = 32;

  logic             clk = 1'b0;
  logic             reset;
  logic [NR*AW-1:0] rd_addr;
  logic [NR*DW-1:0] rd_data;
  logic [AW-1:0]    wr_addr;
  logic [DW-1:0]    wr_data;
  logic             wr_ena;
  logic             clr_req;
  logic             busy;
  logic [AW-1:0]    dbg_addr;
  logic [DW-1:0]    dbg_data;

  always #5 clk = ~clk;

  regfile_bank #(
    .DATA_W(DW), .ADDR_W(AW), .NREAD(NR), .ZERO_REG(1'b1)
  ) dut (
    .clk(clk), .reset(reset), .rd_addr(rd_addr), .rd_data(rd_data),
    .wr_addr(wr_addr), .wr_data(wr_data), .wr_ena(wr_ena), .clr_req(clr_req),
    .busy(busy), .dbg_addr(dbg_addr), .dbg_data(dbg_data)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: array contents, remaining clear cycles, next clear index.
  logic [DW-1:0] m_mem [DEPTH];
  int            m_left = 0;
  int            m_idx  = 0;
  logic [DW-1:0] exp_rd [NR];
  logic [DW-1:0] exp_dbg;
  logic          exp_busy;
  bit            chk_on = 0;
  bit            dbg_on = 0;

  always @(posedge clk) begin : model
    bit busy_now;
    int a;
    busy_now = (m_left > 0);
    for (int k = 0; k < NR; k++) begin
      a = int'(rd_addr[k*AW +: AW]);
      if (reset || busy_now || a == 0) exp_rd[k] = '0;
      else if (wr_ena && int'(wr_addr) == a) exp_rd[k] = wr_data;
      else exp_rd[k] = m_mem[a];
    end
    exp_dbg = (reset || dbg_addr == '0) ? '0 : m_mem[dbg_addr];
    if (busy_now) m_mem[m_idx] = '0;
    else if (wr_ena && !reset && wr_addr != '0) m_mem[wr_addr] = wr_data;
    if (reset || (!busy_now && clr_req)) begin
      m_left = DEPTH;
      m_idx  = 0;
    end else if (busy_now) begin
      m_left--;
      m_idx++;
    end
    exp_busy = (m_left > 0);
    if (reset) chk_on = 1;
    if (chk_on && !exp_busy) dbg_on = 1;
  end

  // Compare process, half a cycle after each active edge.
  always @(negedge clk) begin
    if (chk_on) begin
      check("busy", 64'(busy), 64'(exp_busy));
      for (int k = 0; k < NR; k++)
        check($sformatf("rd%0d", k), 64'(rd_data[k*DW +: DW]), 64'(exp_rd[k]));
      if (dbg_on) check("dbg", 64'(dbg_data), 64'(exp_dbg));
    end
  end

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic set_rd(input int a0, input int a1);
    rd_addr = {AW'(a1), AW'(a0)};
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while (busy && n < 40) begin
      cycle();
      n++;
    end
    check(name, 64'(n), 64'(32));
  endtask

  initial begin
    int n;
    rd_addr = '0; wr_addr = '0; wr_data = '0; wr_ena = 1'b0;
    clr_req = 1'b0; dbg_addr = '0; reset = 1'b1;
    cycle();
    check("rst_busy", 64'(busy), 64'(1));
    check("rst_rd0", 64'(rd_data[31:0]), 64'(0));
    check("rst_dbg", 64'(dbg_data), 64'(0));
    reset = 1'b0;
    wait_idle("reset_clear_len");

    for (int i = 0; i < 32; i++) begin
      set_rd(i, 31 - i);
      dbg_addr = AW'(i);
      cycle();
    end

    wr_ena = 1'b1; wr_addr = 5'd5; wr_data = 32'hDEADBEEF; set_rd(0, 0);
    cycle();
    wr_ena = 1'b0; set_rd(5, 5); dbg_addr = 5'd5;
    cycle();
    check("read5_p0", 64'(rd_data[31:0]), 64'(32'hDEADBEEF));
    check("read5_p1", 64'(rd_data[63:32]), 64'(32'hDEADBEEF));
    check("dbg5", 64'(dbg_data), 64'(32'hDEADBEEF));

    wr_ena = 1'b1; wr_addr = 5'd7; wr_data = 32'h12345678; set_rd(7, 3);
    cycle();
    wr_ena = 1'b0;
    check("bypass7", 64'(rd_data[31:0]), 64'(32'h12345678));
    check("entry3_zero", 64'(rd_data[63:32]), 64'(0));

    wr_ena = 1'b1; wr_addr = 5'd0; wr_data = 32'hFFFFFFFF; set_rd(0, 0); dbg_addr = 5'd0;
    cycle();
    check("zero_bypass", 64'(rd_data[31:0]), 64'(0));
    wr_ena = 1'b0;
    cycle();
    check("zero_read", 64'(rd_data[31:0]), 64'(0));
    check("zero_dbg", 64'(dbg_data), 64'(0));

    for (int i = 1; i < 32; i++) begin
      wr_ena = 1'b1; wr_addr = AW'(i); wr_data = DW'(i);
      cycle();
    end
    wr_ena = 1'b0; set_rd(31, 9);
    cycle();
    check("fill31", 64'(rd_data[31:0]), 64'(31));
    check("fill9", 64'(rd_data[63:32]), 64'(9));

    clr_req = 1'b1;
    cycle();
    clr_req = 1'b0;
    check("clr_busy", 64'(busy), 64'(1));
    n = 0;
    while (busy && n < 40) begin
      if (n == 9) begin
        wr_ena = 1'b1; wr_addr = 5'd3; wr_data = 32'hAA; clr_req = 1'b1; set_rd(3, 3);
      end else begin
        wr_ena = 1'b0; clr_req = 1'b0;
        set_rd(int'($urandom_range(0, 31)), int'($urandom_range(0, 31)));
      end
      cycle();
      check("busy_rd0", 64'(rd_data[31:0]), 64'(0));
      n++;
    end
    check("clr_len", 64'(n), 64'(32));
    wr_ena = 1'b0; clr_req = 1'b0; set_rd(3, 5); dbg_addr = 5'd3;
    cycle();
    check("after_clr3", 64'(rd_data[31:0]), 64'(0));
    check("after_clr5", 64'(rd_data[63:32]), 64'(0));
    check("after_clr_dbg3", 64'(dbg_data), 64'(0));

    clr_req = 1'b1;
    cycle();
    clr_req = 1'b0;
    repeat (15) cycle();
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    check("midclr_rst_busy", 64'(busy), 64'(1));
    wait_idle("restart_clear_len");
    for (int i = 0; i < 32; i++) begin
      set_rd(i, i);
      dbg_addr = AW'(i);
      cycle();
    end

    repeat (2000) begin
      rd_addr  = (NR*AW)'($urandom);
      wr_ena   = 1'($urandom_range(0, 1));
      wr_addr  = AW'($urandom);
      wr_data  = DW'($urandom);
      dbg_addr = AW'($urandom);
      if ($urandom_range(0, 3) == 0) rd_addr[AW-1:0] = wr_addr;
      clr_req  = ($urandom_range(0, 63) == 0);
      reset    = ($urandom_range(0, 255) == 0);
      cycle();
    end
    reset = 1'b0; clr_req = 1'b0; wr_ena = 1'b0;
    cycle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
